div_ctrl: RTL and testbench

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, driven by the decoder/EX stage.

---
 rtl/div_ctrl.sv | 149 ++++++++++++++
 tb/tb_div_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) using a radix-2 restoring divider.
// It stalls the pipeline while it iterates and returns one result per operation to writeback.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic            rd_wen_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic            rem_sel_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_addr_q;

  logic            accept;
  logic            is_signed;
  logic            dvd_neg;
  logic            dsr_neg;
  logic            fast;
  logic [XLEN-1:0] abs_dividend;
  logic [XLEN-1:0] abs_divisor;
  logic [XLEN-1:0] fast_result;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] final_result;

  assign accept    = start_i & ~flush_i;
  assign is_signed = ~op_i[0];
  assign dvd_neg   = is_signed & dividend_i[XLEN-1];
  assign dsr_neg   = is_signed & divisor_i[XLEN-1];

  // Zero divisor and INT_MIN / -1 bypass the iteration with architecturally fixed results.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fast        = 1'b0;
    fast_result = '0;
    abs_dividend = dvd_neg ? -dividend_i : dividend_i;
    abs_divisor  = dsr_neg ? -divisor_i : divisor_i;
    if (divisor_i == '0) begin
      fast        = 1'b1;
      fast_result = op_i[1] ? dividend_i : '1;
    end else if (is_signed && dividend_i == INT_MIN && divisor_i == '1) begin
      fast        = 1'b1;
      fast_result = op_i[1] ? '0 : INT_MIN;
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder and try the subtract.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, divisor_q};
    rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], ~trial[XLEN]};
    if (rem_sel_q) final_result = neg_rem_q ? -rem_next : rem_next;
    else           final_result = neg_quo_q ? -quo_next : quo_next;
  end

  // NOTE: datapath registers are reset along with the FSM so outputs read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      count_q   <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update reading pre-edge values.
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem_sel_q <= op_i[1];
            neg_quo_q <= dvd_neg ^ dsr_neg;
            neg_rem_q <= dvd_neg;
            rd_q      <= rd_addr_i;
            count_q   <= '0;
            divisor_q <= abs_divisor;
            quo_q     <= abs_dividend;
            rem_q     <= '0;
            if (fast) begin
              result_q  <= fast_result;
              rd_addr_q <= rd_addr_i;
              state_q   <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_STEP) begin
              result_q  <= final_result;
              rd_addr_q <= rd_q;
              state_q   <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // DONE is low on stall so the consumer picks up the result in the same cycle.
  assign busy_o    = (state_q != IDLE);
  assign stall_o   = ((state_q == IDLE) & accept) | (state_q == CALC);
  assign valid_o   = (state_q == DONE) & ~flush_i;
  assign rd_wen_o  = valid_o;
  assign rd_addr_o = rd_addr_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized operations
// compared against an arithmetic reference of the RV32M divide rules.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        flush_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        stall_o;
  logic        valid_o;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .stall_o(stall_o), .valid_o(valid_o), .rd_wen_o(rd_wen_o),
    .rd_addr_o(rd_addr_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'd0;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return -32'($urandom_range(1, 20));
    endcase
  endfunction

  // Called at posedge+1. Issues one operation, measures latency in edges from acceptance,
  // and optionally pulses start_i during the busy period at cycle pulse_at.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int pulse_at);
    logic [31:0] exp;
    int          lat;
    int          n;
    exp = ref_result(op, a, b);
    lat = is_fast(op, a, b) ? 1 : 33;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1;
    check("stall_on_start", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
    rd_addr_i = 5'($urandom);
    n = 1;
    while (!valid_o && n < 40) begin
      check("stall_calc", 32'(stall_o), 32'd1);
      if (n == pulse_at) start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("valid", 32'(valid_o), 32'd1);
    check("rd_wen", 32'(rd_wen_o), 32'd1);
    check("stall_done", 32'(stall_o), 32'd0);
    check("result", result_o, exp);
    check("rd_addr", 32'(rd_addr_o), 32'(rd));
    @(posedge clk); #1;
    check("valid_one_cycle", 32'(valid_o), 32'd0);
    check("busy_after", 32'(busy_o), 32'd0);
    check("result_hold", result_o, exp);
    if (pulse_at > 0) begin
      repeat (40) begin
        @(posedge clk); #1;
        check("no_extra_valid", 32'(valid_o), 32'd0);
      end
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    #3;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 0);
    run_op(OP_REM, -32'd7, 32'd2, 5'd4, 0);
    run_op(OP_DIV, -32'd7, 32'd2, 5'd5, 0);
    run_op(OP_DIV, 32'd12345, 32'd0, 5'd6, 0);
    run_op(OP_REMU, 32'd5, 32'd0, 5'd7, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'd1, 5'd11, 0);

    // start_i during CALC is ignored
    run_op(OP_DIV, 32'd1000, -32'd3, 5'd12, 5);

    // Flush in IDLE beats start: no stall, no acceptance
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd2;
    #1;
    check("flush_idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_busy", 32'(busy_o), 32'd0);

    // Flush in CALC at count 10
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd77; divisor_i = 32'd5; rd_addr_i = 5'd13;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("pre_flush_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_calc_busy", 32'(busy_o), 32'd0);
    check("flush_calc_stall", 32'(stall_o), 32'd0);
    cnt = 0;
    repeat (40) begin
      if (valid_o) cnt++;
      @(posedge clk); #1;
    end
    check("flush_calc_no_valid", 32'(cnt), 32'd0);
    run_op(OP_DIVU, 32'd77, 32'd5, 5'd14, 0);

    // Flush in DONE suppresses valid_o
    start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd1; divisor_i = 32'd0; rd_addr_i = 5'd15;
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check("flush_done_valid", 32'(valid_o), 32'd0);
    check("flush_done_wen", 32'(rd_wen_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_done_busy", 32'(busy_o), 32'd0);
    check("flush_done_valid_after", 32'(valid_o), 32'd0);

    // Asynchronous reset mid-CALC
    start_i = 1'b1; op_i = OP_REM; dividend_i = 32'd500; divisor_i = 32'd7; rd_addr_i = 5'd16;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_rd_addr", 32'(rd_addr_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized operations against the reference
    for (int i = 0; i < 60; i++) begin
      run_op(2'($urandom), rand_operand(), rand_operand(), 5'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
